// File: rtl/bypass_scoreboard_pkg.sv
// Shared ISA definitions for the operand bypass / hazard unit.
package bypass_scoreboard_pkg;

    localparam int unsigned NREG = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/bypass_scoreboard_operand_mux.sv
// Per-slot operand resolution: priority search over bypass stages, then the
// long-latency completion port, then register-file data; flags slot hazards.
module bypass_scoreboard_operand_mux
    import bypass_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NSTAGE = 2
) (
    input  reg_idx_t                 rs,
    input  logic [XLEN-1:0]          rf_data,
    input  logic [NSTAGE-1:0]        fwd_valid,
    input  logic [NSTAGE*5-1:0]      fwd_rd,
    input  logic [NSTAGE-1:0]        fwd_ready,
    input  logic [NSTAGE*XLEN-1:0]   fwd_data,
    input  logic                     cpl_valid,
    input  reg_idx_t                 cpl_rd,
    input  logic [XLEN-1:0]          cpl_data,
    input  logic                     pend,
    output logic [XLEN-1:0]          data,
    output logic                     hazard
);

    logic hit;
    logic cpl_hit;

    always_comb begin
        data    = rf_data;
        hazard  = 1'b0;
        hit     = 1'b0;
        cpl_hit = cpl_valid && (cpl_rd == rs);
        if (rs == REG_ZERO) begin
            data = '0;
        end else begin
            // Youngest match decides, so an unready young stage is never masked
            // by an older ready one.
            for (int unsigned s = 0; s < NSTAGE; s++) begin
                if (!hit && fwd_valid[s] && (fwd_rd[s*5 +: 5] == rs)) begin
                    hit    = 1'b1;
                    data   = fwd_data[s*XLEN +: XLEN];
                    hazard = !fwd_ready[s];
                end
            end
            if (!hit && cpl_hit) begin
                data = cpl_data;
            end
            if (pend && !cpl_hit) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass network plus long-latency scoreboard, occupancy counter and
// stall generation for the integer pipeline.
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NSRC    = 2,
    parameter int unsigned NSTAGE  = 2,
    parameter int unsigned MAXLONG = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NSRC*5-1:0]             src_rs,
    input  logic [NSRC*XLEN-1:0]          src_data,
    input  logic [NSTAGE-1:0]             fwd_valid,
    input  logic [NSTAGE*5-1:0]           fwd_rd,
    input  logic [NSTAGE-1:0]             fwd_ready,
    input  logic [NSTAGE*XLEN-1:0]        fwd_data,
    input  logic                          issue_valid,
    input  logic                          issue_long,
    input  logic [4:0]                    issue_rd,
    input  logic                          cpl_valid,
    input  logic [4:0]                    cpl_rd,
    input  logic [XLEN-1:0]               cpl_data,
    output logic [NSRC*XLEN-1:0]          out,
    output logic                          stall,
    output logic [31:0]                   pending,
    output logic [$clog2(MAXLONG+1)-1:0]  long_cnt,
    output logic [31:0]                   stall_cycles
);

    localparam int unsigned CW = $clog2(MAXLONG + 1);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   long_cnt_q, long_cnt_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;

    logic [NSRC-1:0] slot_hazard;
    logic            issue_lv;
    logic            overflow;
    logic            waw;
    logic            set;
    logic            clr;

    for (genvar i = 0; i < NSRC; i++) begin : g_slot
        bypass_scoreboard_operand_mux #(
            .XLEN   (XLEN),
            .NSTAGE (NSTAGE)
        ) u_mux (
            .rs        (src_rs[5*i +: 5]),
            .rf_data   (src_data[XLEN*i +: XLEN]),
            .fwd_valid (fwd_valid),
            .fwd_rd    (fwd_rd),
            .fwd_ready (fwd_ready),
            .fwd_data  (fwd_data),
            .cpl_valid (cpl_valid),
            .cpl_rd    (cpl_rd),
            .cpl_data  (cpl_data),
            .pend      (pending_q[src_rs[5*i +: 5]]),
            .data      (out[XLEN*i +: XLEN]),
            .hazard    (slot_hazard[i])
        );
    end

    always_comb begin
        issue_lv = issue_valid && issue_long;
        clr      = cpl_valid && pending_q[cpl_rd];
        overflow = issue_lv && (long_cnt_q == CW'(MAXLONG)) && !clr;
        waw      = issue_lv && pending_q[issue_rd] && !(cpl_valid && (cpl_rd == issue_rd));
        stall    = (|slot_hazard) || overflow || waw;
        set      = issue_lv && !stall && (issue_rd != REG_ZERO);

        pending_d = pending_q;
        if (clr) begin
            pending_d[cpl_rd] = 1'b0;
        end
        // Applied after the clear so a same-register collision leaves it pending.
        if (set) begin
            pending_d[issue_rd] = 1'b1;
        end
        long_cnt_d = long_cnt_q + CW'(set) - CW'(clr);

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= '0;
            long_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            long_cnt_q     <= long_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending      = pending_q;
    assign long_cnt     = long_cnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: combinational vector table followed by
// multi-cycle scoreboard, overflow, collision and reset sequences.
module tb_bypass_scoreboard;

    localparam int unsigned XLEN = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        src_rs;
    logic [127:0]      src_data;
    logic [1:0]        fwd_valid;
    logic [9:0]        fwd_rd;
    logic [1:0]        fwd_ready;
    logic [127:0]      fwd_data;
    logic              issue_valid;
    logic              issue_long;
    logic [4:0]        issue_rd;
    logic              cpl_valid;
    logic [4:0]        cpl_rd;
    logic [63:0]       cpl_data;
    logic [127:0]      out;
    logic              stall;
    logic [31:0]       pending;
    logic [2:0]        long_cnt;
    logic [31:0]       stall_cycles;

    int total = 0;
    int bad   = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    bypass_scoreboard #(
        .XLEN    (XLEN),
        .NSRC    (2),
        .NSTAGE  (2),
        .MAXLONG (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_rs       (src_rs),
        .src_data     (src_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_ready    (fwd_ready),
        .fwd_data     (fwd_data),
        .issue_valid  (issue_valid),
        .issue_long   (issue_long),
        .issue_rd     (issue_rd),
        .cpl_valid    (cpl_valid),
        .cpl_rd       (cpl_rd),
        .cpl_data     (cpl_data),
        .out          (out),
        .stall        (stall),
        .pending      (pending),
        .long_cnt     (long_cnt),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        string       name;
        logic [4:0]  rs0, rs1;
        logic [1:0]  v, rdy;
        logic [4:0]  rd0, rd1;
        logic [63:0] d0, d1;
        logic        cplv;
        logic [4:0]  cplrd;
        logic [63:0] cpld;
        logic [63:0] exp0, exp1;
        logic        exps;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        src_rs      = '0;
        src_data    = {64'h22, 64'h11};
        fwd_valid   = '0;
        fwd_rd      = '0;
        fwd_ready   = '0;
        fwd_data    = '0;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_rd    = '0;
        cpl_valid   = 1'b0;
        cpl_rd      = '0;
        cpl_data    = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic cpl(input logic [4:0] rd, input logic [63:0] d);
        cpl_valid = 1'b1;
        cpl_rd    = rd;
        cpl_data  = d;
    endtask

    initial begin
        //           name      rs0 rs1 v     rdy    rd0 rd1 d0      d1      cv cr cd        exp0      exp1  exps
        vt[0] = '{"dflt",      5,  0,  2'b11, 2'b11, 5,  5,  64'hAA, 64'hBB, 0, 0, 64'h0,    64'hAA,   64'h0,  0};
        vt[1] = '{"rs0zero",   0,  5,  2'b11, 2'b11, 5,  5,  64'hAA, 64'hBB, 0, 0, 64'h0,    64'h0,    64'hAA, 0};
        vt[2] = '{"nomatch",   3,  5,  2'b11, 2'b11, 5,  5,  64'hAA, 64'hBB, 0, 0, 64'h0,    64'h11,   64'hAA, 0};
        vt[3] = '{"stg1only",  5,  0,  2'b10, 2'b11, 5,  5,  64'hAA, 64'hBB, 0, 0, 64'h0,    64'hBB,   64'h0,  0};
        vt[4] = '{"loaduse",   0,  7,  2'b11, 2'b10, 7,  7,  64'hCC, 64'hDD, 0, 0, 64'h0,    64'h0,    64'hCC, 1};
        vt[5] = '{"ld_done",   0,  7,  2'b10, 2'b11, 7,  7,  64'hCC, 64'hDD, 0, 0, 64'h0,    64'h0,    64'hDD, 0};
        vt[6] = '{"cplbyp",    4,  0,  2'b00, 2'b00, 0,  0,  64'h0,  64'h0,  1, 4, 64'h1234, 64'h1234, 64'h0,  0};
        vt[7] = '{"stg_vs_cpl",4,  0,  2'b10, 2'b11, 0,  4,  64'h0,  64'h77, 1, 4, 64'h1234, 64'h77,   64'h0,  0};
        vt[8] = '{"old_unrdy", 8,  3,  2'b11, 2'b01, 3,  8,  64'h33, 64'h88, 0, 0, 64'h0,    64'h88,   64'h33, 1};
        vt[9] = '{"rd0_stage", 0,  0,  2'b11, 2'b00, 0,  0,  64'h5,  64'h6,  0, 0, 64'h0,    64'h0,    64'h0,  0};

        idle();
        rst = 1'b1;
        #12;
        check("rst_pending", 64'(pending), 64'h0);
        check("rst_cnt", 64'(long_cnt), 64'h0);
        check("rst_sc", 64'(stall_cycles), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle();
            src_rs    = {vt[i].rs1, vt[i].rs0};
            fwd_valid = vt[i].v;
            fwd_ready = vt[i].rdy;
            fwd_rd    = {vt[i].rd1, vt[i].rd0};
            fwd_data  = {vt[i].d1, vt[i].d0};
            cpl_valid = vt[i].cplv;
            cpl_rd    = vt[i].cplrd;
            cpl_data  = vt[i].cpld;
            #1;
            check({vt[i].name, "_out0"}, out[63:0], vt[i].exp0);
            check({vt[i].name, "_out1"}, out[127:64], vt[i].exp1);
            check({vt[i].name, "_stall"}, 64'(stall), 64'(vt[i].exps));
            if (vt[i].exps) exp_sc++;
        end
        @(negedge clk);
        idle();
        #1;
        check("table_sc", 64'(stall_cycles), 64'(exp_sc));
        check("table_pend", 64'(pending), 64'h0);

        // Long op on x9, dependent read stalls, completion bypasses.
        issue(9);
        #1 check("long_issue_stall", 64'(stall), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("long_pend", 64'(pending), 64'h200);
        check("long_cnt1", 64'(long_cnt), 64'h1);
        src_rs = {5'd0, 5'd9};
        #1 check("long_rs_stall", 64'(stall), 64'h1);
        exp_sc++;
        @(negedge clk);
        cpl(9, 64'h1234);
        #1;
        check("cpl_out0", out[63:0], 64'h1234);
        check("cpl_stall", 64'(stall), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("cpl_pend", 64'(pending), 64'h0);
        check("cpl_cnt", 64'(long_cnt), 64'h0);

        // Fill to MAXLONG, then overflow.
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r));
            @(negedge clk);
        end
        idle();
        #1;
        check("full_pend", 64'(pending), 64'h1E);
        check("full_cnt", 64'(long_cnt), 64'h4);
        issue(5);
        #1 check("ovf_stall", 64'(stall), 64'h1);
        exp_sc++;
        @(negedge clk);
        #1;
        check("ovf_cnt", 64'(long_cnt), 64'h4);
        check("ovf_pend", 64'(pending), 64'h1E);
        cpl(1, 64'h0);
        #1 check("ovf_rel_stall", 64'(stall), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("ovf_rel_pend", 64'(pending), 64'h3C);
        check("ovf_rel_cnt", 64'(long_cnt), 64'h4);

        // Free one slot, pend x6, then set/clear collision on x6.
        cpl(2, 64'h0);
        @(negedge clk);
        idle();
        issue(6);
        @(negedge clk);
        idle();
        #1;
        check("pre_col_pend", 64'(pending), 64'h78);
        check("pre_col_cnt", 64'(long_cnt), 64'h4);
        issue(6);
        cpl(6, 64'h66);
        #1 check("col_stall", 64'(stall), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("col_pend", 64'(pending), 64'h78);
        check("col_cnt", 64'(long_cnt), 64'h4);
        cpl(8, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("stray_pend", 64'(pending), 64'h78);
        check("stray_cnt", 64'(long_cnt), 64'h4);

        // Async reset mid-cycle with work outstanding.
        cpl(3, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("pre_rst_pend", 64'(pending), 64'h70);
        check("pre_rst_cnt", 64'(long_cnt), 64'h3);
        check("pre_rst_sc", 64'(stall_cycles), 64'(exp_sc));
        #1 rst = 1'b1;
        #1;
        check("arst_pend", 64'(pending), 64'h0);
        check("arst_cnt", 64'(long_cnt), 64'h0);
        check("arst_sc", 64'(stall_cycles), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cpl(4, 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("post_rst_pend", 64'(pending), 64'h0);
        check("post_rst_cnt", 64'(long_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised operand-bypass and hazard unit for the integer pipeline.
- Sits between register-file read and execute.
- Resolves NSRC source operands against NSTAGE in-flight result stages plus a long-latency completion port (divide, load-miss).
- Tracks outstanding long-latency destinations in a scoreboard and raises a stall for unresolved RAW hazards and scoreboard overflow.

Parameters:
- XLEN, 64, datapath width
- NSRC, 2, number of source operands resolved per cycle
- NSTAGE, 2, number of bypass stages; index 0 is youngest (MA), NSTAGE-1 oldest (WB)
- MAXLONG, 4, maximum outstanding long-latency ops (1..31)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- src_rs  in  NSRC*5  source register indices, slot i at [5i+4:5i]
- src_data  in  NSRC*XLEN  register-file read data per slot
- fwd_valid  in  NSTAGE  stage holds a register-writing instruction
- fwd_rd  in  NSTAGE*5  stage destination index
- fwd_ready  in  NSTAGE  stage result is valid this cycle (0 = load still in flight)
- fwd_data  in  NSTAGE*XLEN  stage result
- issue_valid  in  1  instruction leaving decode this cycle
- issue_long  in  1  issuing instruction is long-latency
- issue_rd  in  5  its destination
- cpl_valid  in  1  long-latency completion
- cpl_rd  in  5  completing destination
- cpl_data  in  XLEN  completing result
- out  out  NSRC*XLEN  resolved operands
- stall  out  1  hold decode/issue this cycle
- pending  out  32  scoreboard bitmap (debug/verification)
- long_cnt  out  $clog2(MAXLONG+1)  outstanding long ops
- stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-high. On reset, pending=0, long_cnt=0, stall_cycles=0.
- Reset mid-operation discards all scoreboard state. Completions arriving afterwards for cleared registers are ignored; the counter never underflows.
- Operand resolution (combinational), per slot i, priority order:
  - rs==0 → 0
  - lowest-index stage s with fwd_valid[s] && fwd_rd[s]==rs && fwd_rd[s]!=0 → fwd_data[s]
  - cpl_valid && cpl_rd==rs → cpl_data
  - otherwise src_data
- Stall conditions (any one asserts stall):
  - Load-use: for any slot, the highest-priority matching stage has fwd_ready==0. An older ready stage does not mask a younger unready one.
  - Scoreboard: pending[rs]==1 for any slot with rs!=0, unless cpl_valid && cpl_rd==rs this cycle (bypassed, no stall).
  - Overflow: issue_valid && issue_long && long_cnt==MAXLONG && !(cpl_valid && pending[cpl_rd]).
  - WAW: issue_valid && issue_long && pending[issue_rd] && !(cpl_valid && cpl_rd==issue_rd).
- stall is 0 whenever issue_valid==0 and no slot hazard exists. Slot hazards assert stall independently of issue_valid.
- Scoreboard update (posedge):
  - set = issue_valid && issue_long && !stall && issue_rd!=0 → pending[issue_rd] <= 1
  - clr = cpl_valid && pending[cpl_rd] → pending[cpl_rd] <= 0
  - Same register set and cleared in one cycle: set wins, pending stays 1.
  - cpl_valid for a non-pending register is ignored (no count change).
  - long_cnt <= long_cnt + set - clr. It is never above MAXLONG and never below 0.
- stall_cycles increments each cycle stall==1 and saturates at 0xFFFF_FFFF.
- Flush is not a port. Flushed instructions are removed by the pipeline dropping fwd_valid. Issued long ops always complete, so the scoreboard is never flushed.
- Latency: out/stall are 0-cycle combinational. pending, long_cnt and stall_cycles reflect updates one cycle after the event.

Decomposition:
- Shared package (isa package): REG_ZERO constant, NREG=32, reg index typedef (5-bit).
- Sub-module operand_mux: one instance per slot, generate loop over NSRC. It performs the priority search over NSTAGE plus the completion port and emits data and hazard.
- The scoreboard, counter and stall logic stay in the top module.

Test Plan:
- Defaults: rs1=5, stage0 rd=5 valid/ready data=0xAA, stage1 rd=5 data=0xBB → out[0]=0xAA, stall=0. Same case with rs1=0 → out[0]=0.
- Load-use: stage0 rd=7 valid ready=0, stage1 rd=7 ready=1, rs2=7 → stall=1. Next cycle stage1 rd=7 ready=1 only → out[1]=stage1 data, stall=0.
- Long op: issue_long rd=9 → pending[9]=1, long_cnt=1. Next cycle rs1=9 → stall=1. cpl_valid rd=9 data=0x1234 → out[0]=0x1234, stall=0, pending[9]=0 next cycle.
- Overflow: 4 long issues rd=1..4, then a 5th → stall=1, long_cnt stays 4. A same-cycle cpl for rd=1 releases it; long_cnt stays 4 with pending={2,3,4,5}.
- Set/clear collision: pending[6]=1, issue_long rd=6 with cpl rd=6 same cycle → no stall, pending[6]=1, long_cnt unchanged. Also cpl rd=8 not pending → ignored.
- Reset mid-run: 3 pending, assert rst asynchronously between edges → pending=0, long_cnt=0, stall_cycles=0 immediately. A stray cpl after reset is ignored.
